// File: rtl/xgriscv_pkg.sv
// Shared definitions for the single-cycle RV32I core: opcodes, ALU and
// immediate encodings, control word and small decode helpers.
package xgriscv_pkg;

   localparam int XLEN = 32;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;

   localparam logic [2:0] F3_WORD   = 3'b010;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
   } alu_op_e;

   typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;

   typedef enum logic [1:0] {WB_ALU, WB_PC4, WB_MEM} wb_sel_e;

   typedef struct packed {
      logic      reg_write;
      logic      mem_write;
      logic      a_pc;
      logic      b_imm;
      logic      branch;
      logic      jal;
      logic      jalr;
      wb_sel_e   wb_sel;
      alu_op_e   alu_op;
      imm_type_e imm_type;
   } ctrl_t;

   // Takes only instr[31:7]; the opcode field never contributes to an immediate.
   function automatic logic [XLEN-1:0] imm_gen(input logic [31:7] ins, input imm_type_e t);
      case (t)
         IMM_S:   return {{20{ins[31]}}, ins[31:25], ins[11:7]};
         IMM_B:   return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
         IMM_U:   return {ins[31:12], 12'b0};
         IMM_J:   return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
         default: return {{20{ins[31]}}, ins[31:20]};
      endcase
   endfunction

   function automatic logic branch_cond(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                        input logic [XLEN-1:0] b);
      case (f3)
         3'b000:  return a == b;
         3'b001:  return a != b;
         3'b100:  return $signed(a) <  $signed(b);
         3'b101:  return $signed(a) >= $signed(b);
         3'b110:  return a <  b;
         3'b111:  return a >= b;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/xgriscv_alu.sv
// 32-bit ALU; shifts use the low five bits of operand b.
module alu
   import xgriscv_pkg::*;
(
   input  alu_op_e         op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic [XLEN-1:0] y
);

   always_comb begin
      case (op)
         ALU_SUB:    y = a - b;
         ALU_SLL:    y = a << b[4:0];
         ALU_SLT:    y = {31'b0, $signed(a) < $signed(b)};
         ALU_SLTU:   y = {31'b0, a < b};
         ALU_XOR:    y = a ^ b;
         ALU_SRL:    y = a >> b[4:0];
         ALU_SRA:    y = $unsigned($signed(a) >>> b[4:0]);
         ALU_OR:     y = a | b;
         ALU_AND:    y = a & b;
         ALU_PASS_B: y = b;
         default:    y = a + b;
      endcase
   end

endmodule

// File: rtl/xgriscv_controller.sv
// Main decoder: opcode/funct fields to the datapath control word.
module controller
   import xgriscv_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   output ctrl_t      ctrl
);

   // Bit 30 selects SUB only for register-register ops; in OP-IMM it is immediate data.
   function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic b30, input logic is_op);
      case (f3)
         3'b000:  return (is_op && b30) ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return b30 ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   // NOTE: every field gets a default before the case so unlisted opcodes
   // decode to a NOP and no latch is inferred.
   always_comb begin
      ctrl          = '0;
      ctrl.alu_op   = ALU_ADD;
      ctrl.imm_type = IMM_I;
      ctrl.wb_sel   = WB_ALU;
      case (opcode)
         OP_LUI: begin
            ctrl.reg_write = 1'b1;
            ctrl.b_imm     = 1'b1;
            ctrl.imm_type  = IMM_U;
            ctrl.alu_op    = ALU_PASS_B;
         end
         OP_AUIPC: begin
            ctrl.reg_write = 1'b1;
            ctrl.a_pc      = 1'b1;
            ctrl.b_imm     = 1'b1;
            ctrl.imm_type  = IMM_U;
         end
         OP_JAL: begin
            ctrl.reg_write = 1'b1;
            ctrl.jal       = 1'b1;
            ctrl.wb_sel    = WB_PC4;
            ctrl.imm_type  = IMM_J;
         end
         OP_JALR: begin
            ctrl.reg_write = 1'b1;
            ctrl.jalr      = 1'b1;
            ctrl.wb_sel    = WB_PC4;
         end
         OP_BRANCH: begin
            ctrl.branch   = 1'b1;
            ctrl.imm_type = IMM_B;
         end
         OP_LOAD: begin
            if (funct3 == F3_WORD) begin
               ctrl.reg_write = 1'b1;
               ctrl.b_imm     = 1'b1;
               ctrl.wb_sel    = WB_MEM;
            end
         end
         OP_STORE: begin
            if (funct3 == F3_WORD) begin
               ctrl.mem_write = 1'b1;
               ctrl.b_imm     = 1'b1;
               ctrl.imm_type  = IMM_S;
            end
         end
         OP_IMM: begin
            ctrl.reg_write = 1'b1;
            ctrl.b_imm     = 1'b1;
            ctrl.alu_op    = alu_decode(funct3, funct7b5, 1'b0);
         end
         OP_OP: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = alu_decode(funct3, funct7b5, 1'b1);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/xgriscv_dmem.sv
// Data memory: combinational word read, word write on the rising edge.
module dmem
   import xgriscv_pkg::*;
#(
   parameter int DEPTH = 1024
) (
   input  logic            clk,
   input  logic            we,
   input  logic [XLEN-1:0] addr,
   input  logic [XLEN-1:0] wd,
   output logic [XLEN-1:0] rd
);

   localparam int AW = $clog2(DEPTH);

   logic [XLEN-1:0] RAM [0:DEPTH-1];
   logic [AW-1:0]   idx;
   logic            unused_addr_bits;

   assign idx              = addr[AW+1:2];
   assign unused_addr_bits = ^{addr[XLEN-1:AW+2], addr[1:0]};

   always_ff @(posedge clk) begin
      if (we) RAM[idx] <= wd;
   end

   assign rd = RAM[idx];

endmodule

// File: rtl/xgriscv_imem.sv
// Instruction memory: combinational word read, contents supplied externally.
module imem
   import xgriscv_pkg::*;
#(
   parameter int DEPTH = 1024
) (
   input  logic [XLEN-1:0] addr,
   output logic [XLEN-1:0] rd
);

   localparam int AW = $clog2(DEPTH);

   logic [XLEN-1:0] RAM [0:DEPTH-1];
   logic            unused_addr_bits;

   assign rd               = RAM[addr[AW+1:2]];
   assign unused_addr_bits = ^{addr[XLEN-1:AW+2], addr[1:0]};

endmodule

// File: rtl/xgriscv_regfile.sv
// 32x32 register file: two combinational read ports, one clocked write port.
module regfile
   import xgriscv_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            we,
   input  logic [4:0]      ra1,
   input  logic [4:0]      ra2,
   input  logic [4:0]      wa,
   input  logic [XLEN-1:0] wd,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2
);

   logic [XLEN-1:0] rf [0:31];

   // NOTE: the architectural registers must come out of reset at zero, so this
   // array is cleared; the instruction/data RAMs are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) rf[i] <= '0;
      end else if (we && wa != 5'd0) begin
         rf[wa] <= wd;
      end
   end

   assign rd1 = (ra1 == 5'd0) ? '0 : rf[ra1];
   assign rd2 = (ra2 == 5'd0) ? '0 : rf[ra2];

endmodule

// File: rtl/xgriscv_sc.sv
// Single-cycle RV32I core: fetch through writeback in one clock, Harvard memories.
module xgriscv_sc
   import xgriscv_pkg::*;
#(
   parameter int IMEM_DEPTH = 1024,
   parameter int DMEM_DEPTH = 1024
) (
   input  logic            clk,
   input  logic            rstn,
   output logic [XLEN-1:0] pcW
);

   logic [XLEN-1:0] pc, pc_plus4, pc_next, instr, imm;
   logic [XLEN-1:0] rd1, rd2, src_a, src_b, alu_result, mem_rd, wb_data;
   ctrl_t           ctrl;
   logic            taken;

   // rstn is an active-high reset despite its name.
   always_ff @(posedge clk) begin
      if (rstn) pc <= '0;
      else      pc <= pc_next;
   end

   assign pcW = pc;

   imem #(.DEPTH(IMEM_DEPTH)) U_imem (
      .addr (pc),
      .rd   (instr)
   );

   controller U_controller (
      .opcode   (instr[6:0]),
      .funct3   (instr[14:12]),
      .funct7b5 (instr[30]),
      .ctrl     (ctrl)
   );

   assign imm = imm_gen(instr[31:7], ctrl.imm_type);

   regfile U_regfile (
      .clk (clk),
      .rst (rstn),
      .we  (ctrl.reg_write),
      .ra1 (instr[19:15]),
      .ra2 (instr[24:20]),
      .wa  (instr[11:7]),
      .wd  (wb_data),
      .rd1 (rd1),
      .rd2 (rd2)
   );

   assign src_a = ctrl.a_pc  ? pc  : rd1;
   assign src_b = ctrl.b_imm ? imm : rd2;

   alu U_alu (
      .op (ctrl.alu_op),
      .a  (src_a),
      .b  (src_b),
      .y  (alu_result)
   );

   // A store in the reset cycle is dropped so the aborted instruction leaves no trace.
   dmem #(.DEPTH(DMEM_DEPTH)) U_dmem (
      .clk  (clk),
      .we   (ctrl.mem_write & ~rstn),
      .addr (alu_result),
      .wd   (rd2),
      .rd   (mem_rd)
   );

   assign taken    = ctrl.branch & branch_cond(instr[14:12], rd1, rd2);
   assign pc_plus4 = pc + 32'd4;

   always_comb begin
      if (ctrl.jalr)                pc_next = (rd1 + imm) & ~32'd1;
      else if (ctrl.jal || taken)   pc_next = pc + imm;
      else                          pc_next = pc_plus4;
   end

   always_comb begin
      case (ctrl.wb_sel)
         WB_PC4:  wb_data = pc_plus4;
         WB_MEM:  wb_data = mem_rd;
         default: wb_data = alu_result;
      endcase
   end

endmodule

// File: tb/tb_xgriscv_sc.sv
// Directed-program bench for xgriscv_sc: hand-assembled programs, hand-computed results.
module tb_xgriscv_sc;

   logic        clk  = 1'b0;
   logic        rstn = 1'b1;
   logic [31:0] pcW;
   int          n_checks = 0;
   int          n_fail   = 0;
   int          wp       = 0;

   localparam logic [6:0] OPI = 7'h13, OPR = 7'h33, LUI = 7'h37, AUIPC = 7'h17;
   localparam logic [6:0] JALR = 7'h67, LOAD = 7'h03;

   xgriscv_sc #(.IMEM_DEPTH(1024), .DMEM_DEPTH(1024)) dut (
      .clk  (clk),
      .rstn (rstn),
      .pcW  (pcW)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rf(input int i);
      return dut.U_regfile.rf[i];
   endfunction

   function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                         input int rd, input logic [6:0] op);
      logic [31:0] v, s, f, d;
      v = imm; s = rs1; f = f3; d = rd;
      return {v[11:0], s[4:0], f[2:0], d[4:0], op};
   endfunction

   function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                         input int f3, input int rd);
      logic [31:0] g, t, s, f, d;
      g = f7; t = rs2; s = rs1; f = f3; d = rd;
      return {g[6:0], t[4:0], s[4:0], f[2:0], d[4:0], OPR};
   endfunction

   function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
      logic [31:0] v, t, s, f;
      v = imm; t = rs2; s = rs1; f = f3;
      return {v[11:5], t[4:0], s[4:0], f[2:0], v[4:0], 7'h23};
   endfunction

   function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
      logic [31:0] v, t, s, f;
      v = imm; t = rs2; s = rs1; f = f3;
      return {v[12], v[10:5], t[4:0], s[4:0], f[2:0], v[4:1], v[11], 7'h63};
   endfunction

   function automatic logic [31:0] enc_u(input int imm20, input int rd, input logic [6:0] op);
      logic [31:0] v, d;
      v = imm20; d = rd;
      return {v[19:0], d[4:0], op};
   endfunction

   function automatic logic [31:0] enc_j(input int imm, input int rd);
      logic [31:0] v, d;
      v = imm; d = rd;
      return {v[20], v[10:1], v[11], v[19:12], d[4:0], 7'h6f};
   endfunction

   // Holds the core in reset and fills the low instruction memory with NOPs.
   task automatic begin_prog();
      rstn = 1'b1;
      for (int k = 0; k < 128; k++) dut.U_imem.RAM[k] = 32'h0000_0013;
      wp = 0;
   endtask

   task automatic put(input logic [31:0] w);
      dut.U_imem.RAM[wp >> 2] = w;
      wp += 4;
   endtask

   task automatic release_reset();
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rstn = 1'b0;
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      logic [31:0] acc;

      // Two dependent ADDIs and the pc sequence.
      begin_prog();
      put(enc_i(5, 0, 0, 1, OPI));
      put(enc_i(-3, 1, 0, 2, OPI));
      release_reset();
      check("t1_pc0", pcW, 32'h0);
      step(1);
      check("t1_pc1", pcW, 32'h4);
      check("t1_x1", rf(1), 32'd5);
      step(1);
      check("t1_pc2", pcW, 32'h8);
      check("t1_x2", rf(2), 32'd2);

      // LUI/ADDI build a word, store it, load it back.
      begin_prog();
      put(enc_u(32'h12345, 3, LUI));
      put(enc_i(32'h678, 3, 0, 3, OPI));
      put(enc_s(8, 3, 0, 2));
      put(enc_i(8, 0, 2, 4, LOAD));
      release_reset();
      step(4);
      check("t2_x3", rf(3), 32'h1234_5678);
      check("t2_mem", dut.U_dmem.RAM[2], 32'h1234_5678);
      check("t2_x4", rf(4), 32'h1234_5678);

      // Unsigned branch taken, signed branch not taken on 0 vs -1.
      begin_prog();
      put(enc_i(-1, 0, 0, 1, OPI));
      put(enc_b(8, 1, 0, 6));
      put(enc_i(1, 0, 0, 9, OPI));
      put(enc_b(8, 1, 0, 4));
      release_reset();
      step(1);
      check("t3_x1", rf(1), 32'hFFFF_FFFF);
      step(1);
      check("t3_bltu_pc", pcW, 32'hC);
      step(1);
      check("t3_blt_pc", pcW, 32'h10);
      check("t3_x9", rf(9), 32'h0);

      // JAL forward then JALR back to the link address.
      begin_prog();
      wp = 32'h10;
      put(enc_j(16, 1));
      put(enc_i(3, 0, 0, 6, OPI));
      wp = 32'h20;
      put(enc_i(0, 1, 0, 0, JALR));
      release_reset();
      step(4);
      check("t4_pc_jal", pcW, 32'h10);
      step(1);
      check("t4_pc_tgt", pcW, 32'h20);
      check("t4_x1", rf(1), 32'h14);
      step(1);
      check("t4_pc_jalr", pcW, 32'h14);
      step(1);
      check("t4_x6", rf(6), 32'd3);
      check("t4_pc_after", pcW, 32'h18);

      // x0 stays zero; unsupported encodings retire as NOPs.
      begin_prog();
      put(enc_i(9, 0, 0, 5, OPI));
      put(enc_i(7, 0, 0, 0, OPI));
      put(enc_r(0, 0, 0, 0, 5));
      put(enc_i(9, 0, 0, 5, OPI));
      put(32'h0000_007F);
      put(32'h0000_02FF);
      put(enc_s(0, 5, 0, 0));
      put(enc_i(0, 0, 0, 7, LOAD));
      dut.U_dmem.RAM[0] = 32'hAAAA_5555;
      release_reset();
      step(2);
      check("t5_x0", rf(0), 32'h0);
      step(1);
      check("t5_x5_zero", rf(5), 32'h0);
      step(3);
      check("t5_x5_kept", rf(5), 32'd9);
      check("t5_pc_nop", pcW, 32'h18);
      step(2);
      check("t5_sb_ignored", dut.U_dmem.RAM[0], 32'hAAAA_5555);
      check("t5_lb_ignored", rf(7), 32'h0);
      check("t5_pc_end", pcW, 32'h20);

      // ALU corner cases: shifts, signed/unsigned compares, AUIPC.
      begin_prog();
      put(enc_i(-8, 0, 0, 1, OPI));
      put(enc_i(32'h401, 1, 5, 2, OPI));
      put(enc_i(28, 1, 5, 3, OPI));
      put(enc_r(32, 1, 0, 0, 4));
      put(enc_r(0, 0, 1, 2, 5));
      put(enc_r(0, 0, 1, 3, 6));
      put(enc_r(0, 4, 4, 1, 7));
      put(enc_i(-1, 1, 4, 8, OPI));
      put(enc_i(-1, 1, 3, 9, OPI));
      put(enc_u(1, 11, AUIPC));
      release_reset();
      step(10);
      check("t7_srai", rf(2), 32'hFFFF_FFFC);
      check("t7_srli", rf(3), 32'h0000_000F);
      check("t7_sub", rf(4), 32'd8);
      check("t7_slt", rf(5), 32'd1);
      check("t7_sltu", rf(6), 32'd0);
      check("t7_sll", rf(7), 32'h0000_0800);
      check("t7_xori", rf(8), 32'd7);
      check("t7_sltiu", rf(9), 32'd1);
      check("t7_auipc", rf(11), 32'h0000_1024);

      // Mid-program reset aborts the store at 0x40 and restarts at 0.
      begin_prog();
      for (int k = 0; k < 16; k++) put(enc_i(1, 1, 0, 1, OPI));
      put(enc_s(4, 1, 0, 2));
      dut.U_dmem.RAM[1] = 32'hDEAD_BEEF;
      release_reset();
      step(16);
      check("t6_pc_40", pcW, 32'h40);
      check("t6_x1_16", rf(1), 32'd16);
      rstn = 1'b1;
      step(1);
      check("t6_pc_rst", pcW, 32'h0);
      acc = '0;
      for (int i = 0; i < 32; i++) acc |= rf(i);
      check("t6_regs_rst", acc, 32'h0);
      check("t6_no_store", dut.U_dmem.RAM[1], 32'hDEAD_BEEF);
      rstn = 1'b0;
      step(1);
      check("t6_pc_restart", pcW, 32'h4);
      check("t6_x1_restart", rf(1), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
